// File: rtl/bus_multiplexer_pkg.sv
// Shared types and helpers for the wide-to-byte bus multiplexer.
package bus_multiplexer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LANE = 2'd1,
    GAPW = 2'd2,
    DONE = 2'd3
  } bm_state_e;

  localparam int BYTE_W = 8;

  function automatic int lane_slice(input int index);
    return BYTE_W * index;
  endfunction

endpackage

// File: rtl/bus_multiplexer.sv
// Splits one wide CPU access into LANES byte-bus accesses, highest byte address first,
// with programmable wait states, turbo bypass and an optional idle gap between lanes.
//
// state | meaning
// IDLE  | no byte-bus access in progress
// LANE  | strobe active on lane a_lane; waiting out cnt, then for sysrdy
// GAPW  | strobe low between two lanes for GAP ticks
// DONE  | all lanes captured; READY to CPU until the access ends
module bus_multiplexer
  import bus_multiplexer_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int LANE_BITS   = $clog2(LANES),
  parameter int WAIT_STATES = 4,
  parameter int GAP         = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic                      turbo,
  input  logic                      start,
  input  logic                      memen,
  input  logic                      sysrdy,
  output logic                      memen8,
  output logic                      ready,
  output logic [LANE_BITS-1:0]      a_lane,
  input  logic [BYTE_W-1:0]         d8,
  output logic [BYTE_W-1:0]         q8,
  output logic [BYTE_W*LANES-1:0]   d,
  input  logic [BYTE_W*LANES-1:0]   q
);

  localparam int                   CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [LANE_BITS-1:0] LAST     = LANE_BITS'(LANES - 1);
  localparam logic [1:0]           GAP_LOAD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  bm_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, wait_val;
  logic [1:0]           gap_cnt, gap_nxt;
  logic [LANE_BITS-1:0] lane_nxt;
  logic                 memen8_nxt;
  logic                 capture, preset;
  logic                 access;
  logic [BYTE_W-1:0]    byte_q [LANES];

  assign access   = memen && start;
  assign ready    = (state == DONE) || !access;
  assign wait_val = turbo ? '0 : CNT_W'(WAIT_STATES);

  // Lane 0 is the most significant byte of the wide word.
  assign q8 = q[lane_slice(LANES - 1 - int'(a_lane)) +: BYTE_W];

  for (genvar i = 0; i < LANES; i++) begin : g_d
    assign d[lane_slice(LANES - 1 - i) +: BYTE_W] = byte_q[i];
  end

  always_comb begin
    state_nxt  = state;
    memen8_nxt = memen8;
    lane_nxt   = a_lane;
    cnt_nxt    = cnt;
    gap_nxt    = gap_cnt;
    capture    = 1'b0;
    preset     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          state_nxt  = LANE;
          lane_nxt   = LAST;
          cnt_nxt    = wait_val;
          memen8_nxt = 1'b1;
          preset     = 1'b1;
        end
      end
      LANE: begin
        // An abort wins over a capture landing on the same tick.
        if (!access) begin
          state_nxt  = IDLE;
          memen8_nxt = 1'b0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (sysrdy) begin
          capture = 1'b1;
          if (a_lane == '0) begin
            memen8_nxt = 1'b0;
            state_nxt  = DONE;
          end else begin
            lane_nxt = a_lane - 1'b1;
            cnt_nxt  = wait_val;
            if (GAP > 0) begin
              memen8_nxt = 1'b0;
              gap_nxt    = GAP_LOAD;
              state_nxt  = GAPW;
            end
          end
        end
      end
      GAPW: begin
        if (!access) begin
          state_nxt  = IDLE;
          memen8_nxt = 1'b0;
        end else if (gap_cnt == 2'd0) begin
          memen8_nxt = 1'b1;
          state_nxt  = LANE;
        end else begin
          gap_nxt = gap_cnt - 2'd1;
        end
      end
      DONE: begin
        if (!access) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memen8  <= 1'b0;
      a_lane  <= LAST;
      cnt     <= '0;
      gap_cnt <= 2'd0;
      for (int i = 0; i < LANES; i++) byte_q[i] <= 8'hFF;
    end else if (clk_en) begin
      memen8  <= memen8_nxt;
      a_lane  <= lane_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_nxt;
      if (preset) begin
        for (int i = 0; i < LANES; i++) byte_q[i] <= 8'hFF;
      end
      if (capture) byte_q[a_lane] <= d8;
    end
  end

endmodule
